// File: rtl/axistream_pack_pkg.sv
// Shared helpers for the narrow/wide AXI-Stream pack and unpack converters.
package axistream_pack_pkg;

    // Ceiling log2 with a floor of 1, used to size lane counters.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

    // Lane written by beat k of a word.
    function automatic int unsigned lane(input int unsigned k, input logic big_endian,
                                         input int unsigned num_pack);
        return big_endian ? (num_pack - 1 - k) : k;
    endfunction

endpackage

// File: rtl/axistream_pack.sv
// Narrow-to-wide AXI-Stream converter: packs NUM_PACK beats into one word,
// flushing a partial (tkeep-qualified) word on an early src_tlast.
module axistream_pack
    import axistream_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4,
    parameter logic        BIG_ENDIAN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           src_tvalid,
    output logic                           src_tready,
    input  logic [DATA_WIDTH-1:0]          src_tdata,
    input  logic                           src_tlast,
    output logic                           dest_tvalid,
    input  logic                           dest_tready,
    output logic [NUM_PACK*DATA_WIDTH-1:0] dest_tdata,
    output logic [NUM_PACK-1:0]            dest_tkeep,
    output logic                           dest_tlast
);

    localparam int unsigned IDX_W  = clog2(NUM_PACK);
    localparam int unsigned WORD_W = NUM_PACK * DATA_WIDTH;

    if (NUM_PACK < 2) begin : g_bad_num_pack
        $error("axistream_pack: NUM_PACK must be >= 2");
    end

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   acc_data_q, acc_data_d;
    logic [NUM_PACK-1:0] acc_keep_q, acc_keep_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [NUM_PACK-1:0] out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic                beat_fire;
    logic                word_done;
    logic [IDX_W-1:0]    lane_sel;
    logic [WORD_W-1:0]   merged_data;
    logic [NUM_PACK-1:0] merged_keep;

    // Ready is held low in reset so nothing is accepted before the counter is sane.
    assign src_tready = rst_n && (!out_valid_q || dest_tready);

    assign dest_tvalid = out_valid_q;
    assign dest_tdata  = out_data_q;
    assign dest_tkeep  = out_keep_q;
    assign dest_tlast  = out_last_q;

    always_comb begin
        beat_fire   = src_tvalid && src_tready;
        word_done   = beat_fire && ((idx_q == IDX_W'(NUM_PACK - 1)) || src_tlast);
        lane_sel    = IDX_W'(lane(32'(idx_q), BIG_ENDIAN, NUM_PACK));
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int unsigned i = 0; i < NUM_PACK; i++) begin
            if (lane_sel == IDX_W'(i)) begin
                merged_data[i*DATA_WIDTH +: DATA_WIDTH] = src_tdata;
                merged_keep[i]                          = 1'b1;
            end
        end

        idx_d       = idx_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && dest_tready) begin
            out_valid_d = 1'b0;
        end

        // A completing beat may load on the same edge the previous word drains.
        if (word_done) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = src_tlast;
            out_valid_d = 1'b1;
            idx_d       = '0;
            acc_data_d  = '0;
            acc_keep_d  = '0;
        end else if (beat_fire) begin
            acc_data_d = merged_data;
            acc_keep_d = merged_keep;
            idx_d      = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_axistream_pack.sv
// Bench for axistream_pack: big- and little-endian instances share one stream.
module tb_axistream_pack;

    logic        clk;
    logic        rst_n;
    logic        src_tvalid;
    logic [7:0]  src_tdata;
    logic        src_tlast;
    logic        dest_tready;

    logic        be_src_tready, le_src_tready;
    logic        be_valid, le_valid;
    logic [31:0] be_data, le_data;
    logic [3:0]  be_keep, le_keep;
    logic        be_last, le_last;

    typedef struct {
        logic [31:0] be_data;
        logic [31:0] le_data;
        logic [3:0]  be_keep;
        logic [3:0]  le_keep;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(be_src_tready),
        .src_tdata(src_tdata), .src_tlast(src_tlast),
        .dest_tvalid(be_valid), .dest_tready(dest_tready),
        .dest_tdata(be_data), .dest_tkeep(be_keep), .dest_tlast(be_last)
    );

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(le_src_tready),
        .src_tdata(src_tdata), .src_tlast(src_tlast),
        .dest_tvalid(le_valid), .dest_tready(dest_tready),
        .dest_tdata(le_data), .dest_tkeep(le_keep), .dest_tlast(le_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] bd, input logic [31:0] ld,
                        input logic [3:0] bk, input logic [3:0] lk, input logic l);
        exp_t e;
        e.be_data = bd; e.le_data = ld; e.be_keep = bk; e.le_keep = lk; e.last = l;
        exp_q.push_back(e);
    endtask

    // Drive one beat from posedge+1 until accepted; reports cycles stalled.
    task automatic send(input logic [7:0] d, input logic l, output int stalls);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = l;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = be_src_tready;
            @(posedge clk);
            #1;
            if (!ok) stalls++;
        end
        if (!ok) begin
            vectors++;
            fails++;
            $error("FAIL send_timeout: beat %h observed not accepted expected accepted", d);
        end
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    // Scoreboard: every transferred word is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && dest_tready && (be_valid || le_valid)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $error("FAIL unexpected_word: observed %h expected no word", be_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("be_valid", 32'(be_valid), 32'd1);
                chk("le_valid", 32'(le_valid), 32'd1);
                chk("be_data", be_data, e.be_data);
                chk("le_data", le_data, e.le_data);
                chk("be_keep", 32'(be_keep), 32'(e.be_keep));
                chk("le_keep", 32'(le_keep), 32'(e.le_keep));
                chk("be_last", 32'(be_last), 32'(e.last));
                chk("le_last", 32'(le_last), 32'(e.last));
            end
        end
    end

    initial begin
        int st;
        rst_n       = 1'b0;
        src_tvalid  = 1'b0;
        src_tdata   = 8'h00;
        src_tlast   = 1'b0;
        dest_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(be_valid), 32'd0);
        chk("rst_data", be_data, 32'd0);
        chk("rst_keep", 32'(be_keep), 32'd0);
        chk("rst_last", 32'(be_last), 32'd0);
        chk("rst_src_tready", 32'(be_src_tready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full word, both lane orders; src_tready must not drop
        push(32'h11223344, 32'h44332211, 4'hF, 4'hF, 1'b1);
        send(8'h11, 1'b0, st); chk("t1_stall0", 32'(st), 32'd0);
        send(8'h22, 1'b0, st); chk("t1_stall1", 32'(st), 32'd0);
        send(8'h33, 1'b0, st); chk("t1_stall2", 32'(st), 32'd0);
        send(8'h44, 1'b1, st); chk("t1_stall3", 32'(st), 32'd0);
        @(posedge clk); #1;

        // Early tlast flushes a partial word, then a full one follows
        push(32'hAABB0000, 32'h0000BBAA, 4'b1100, 4'b0011, 1'b1);
        push(32'hCCDDEEFF, 32'hFFEEDDCC, 4'hF, 4'hF, 1'b1);
        send(8'hAA, 1'b0, st);
        send(8'hBB, 1'b1, st);
        send(8'hCC, 1'b0, st);
        send(8'hDD, 1'b0, st);
        send(8'hEE, 1'b0, st);
        send(8'hFF, 1'b1, st);
        @(posedge clk); #1;

        // Backpressure: pending word must hold and block new beats
        dest_tready = 1'b0;
        push(32'h10111213, 32'h13121110, 4'hF, 4'hF, 1'b1);
        push(32'h20212223, 32'h23222120, 4'hF, 4'hF, 1'b1);
        send(8'h10, 1'b0, st);
        send(8'h11, 1'b0, st);
        send(8'h12, 1'b0, st);
        send(8'h13, 1'b1, st);
        src_tvalid = 1'b1;
        src_tdata  = 8'h20;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_src_tready", 32'(be_src_tready), 32'd0);
            chk("hold_valid", 32'(be_valid), 32'd1);
            chk("hold_data", be_data, 32'h10111213);
            chk("hold_keep", 32'(be_keep), 32'hF);
            chk("hold_last", 32'(be_last), 32'd1);
            @(posedge clk); #1;
        end
        dest_tready = 1'b1;
        send(8'h20, 1'b0, st);
        send(8'h21, 1'b0, st);
        send(8'h22, 1'b0, st);
        send(8'h23, 1'b1, st);
        @(posedge clk); #1;

        // Reset while a word is pending drops dest_tvalid at once
        dest_tready = 1'b0;
        send(8'h99, 1'b1, st);
        chk("pend_valid", 32'(be_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(be_valid), 32'd0);
        chk("arst_data", be_data, 32'd0);
        chk("arst_keep", 32'(be_keep), 32'd0);
        chk("arst_src_tready", 32'(be_src_tready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dest_tready = 1'b1;

        // Reset mid-word discards the partial accumulator
        send(8'h77, 1'b0, st);
        send(8'h78, 1'b0, st);
        #2 rst_n = 1'b0;
        #1;
        chk("arst2_valid", 32'(be_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(32'h01020304, 32'h04030201, 4'hF, 4'hF, 1'b1);
        send(8'h01, 1'b0, st);
        send(8'h02, 1'b0, st);
        send(8'h03, 1'b0, st);
        send(8'h04, 1'b1, st);
        @(posedge clk); #1;

        // Back-to-back two-word packet with no stalls
        push(32'h01020304, 32'h04030201, 4'hF, 4'hF, 1'b0);
        push(32'h05060708, 32'h08070605, 4'hF, 4'hF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), (i == 8), st);
            chk("b2b_stall", 32'(st), 32'd0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
